// File: rtl/reg_readback.sv
// Debug readback sequencer: sweeps a synchronous-read register array from address 0
// to NREGS-1 and streams each {addr, data} word out over a valid/ready interface.
module reg_readback #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t             state;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_addr;
    logic [WIDTH-1:0]   buf_data [2];
    logic [ADDR_W-1:0]  buf_addr [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push;
    logic               pop;
    logic               last_pop;
    logic [2:0]         occupancy;

    // A read may issue only if the buffer can hold it after its data returns, so
    // buffered words plus the word on rd_data, less any word leaving now, must be < 2.
    always_comb begin
        push      = inflight;
        pop       = out_valid && out_ready;
        occupancy = {1'b0, count} + {2'b00, inflight};
        rd_en     = (state == SWEEP) && (occupancy < (3'd2 + {2'b00, pop}));
        last_pop  = (state == DRAIN) && pop && (count == 2'd1) && !inflight;
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = buf_data[rd_ptr];
    assign out_addr  = buf_addr[rd_ptr];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            done          <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_addr[i] <= '0;
            end
        end else begin
            done <= last_pop;

            case (state)
                IDLE: begin
                    // The done cycle still counts as part of the finished sweep.
                    if (start && !done) begin
                        state   <= SWEEP;
                        rd_addr <= '0;
                    end
                end
                SWEEP: begin
                    if (rd_en) begin
                        if (rd_addr == LAST) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            inflight <= rd_en;
            if (rd_en) begin
                inflight_addr <= rd_addr;
            end

            if (push) begin
                buf_data[wr_ptr] <= rd_data;
                buf_addr[wr_ptr] <= inflight_addr;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_readback.sv
// Self-checking bench for reg_readback: an NREGS=8 instance and an NREGS=1 instance,
// each fed by a behavioural synchronous-read RAM.
module tb_reg_readback;

    logic       clk = 1'b0;
    logic       reset;
    logic       start,  busy,  rd_en,  out_valid,  out_ready,  done;
    logic [2:0] rd_addr,  out_addr;
    logic [7:0] rd_data,  out_data;
    logic       start1, busy1, rd_en1, out_valid1, out_ready1, done1;
    logic [2:0] rd_addr1, out_addr1;
    logic [7:0] rd_data1, out_data1;

    logic [7:0] mem  [8];
    logic [7:0] mem1 [8];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    reg_readback #(.WIDTH(8), .ADDR_W(3), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .done(done)
    );

    reg_readback #(.WIDTH(8), .ADDR_W(3), .NREGS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .rd_en(rd_en1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .out_addr(out_addr1), .done(done1)
    );

    // Storage returns the addressed word one cycle after the read request.
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en1) rd_data1 <= mem1[rd_addr1];
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; out_ready1 = 1'b0;
        step();
        step();
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (rd_en !== 1'b0)     begin mismatched++; $display("[TB] FAIL reset_rd_en: got %b expected 0", rd_en); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++; if (done !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        compared++; if (rd_addr !== 3'd0)   begin mismatched++; $display("[TB] FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        compared++; if (out_data !== 8'd0)  begin mismatched++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
        compared++; if (out_addr !== 3'd0)  begin mismatched++; $display("[TB] FAIL reset_out_addr: got %0d expected 0", out_addr); end
        compared++; if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_single: got busy=%b valid=%b expected 0/0", busy1, out_valid1);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c <= 10; c++) begin
            logic exp_valid;
            exp_valid = (c >= 2) && (c <= 9);
            compared++; if (out_valid !== exp_valid) begin mismatched++; $display("[TB] FAIL free_valid c=%0d: got %b expected %b", c, out_valid, exp_valid); end
            if (exp_valid) begin
                compared++; if (out_addr !== 3'(c - 2) || out_data !== 8'(8'h10 + c - 2)) begin
                    mismatched++; $display("[TB] FAIL free_word c=%0d: got %0d/%h expected %0d/%h", c, out_addr, out_data, c - 2, 8'h10 + c - 2);
                end
            end
            compared++; if (rd_en !== (c <= 7)) begin mismatched++; $display("[TB] FAIL free_rd_en c=%0d: got %b expected %b", c, rd_en, c <= 7); end
            if (c <= 7) begin
                compared++; if (rd_addr !== 3'(c)) begin mismatched++; $display("[TB] FAIL free_rd_addr c=%0d: got %0d expected %0d", c, rd_addr, c); end
            end
            compared++; if (busy !== (c <= 9)) begin mismatched++; $display("[TB] FAIL free_busy c=%0d: got %b expected %b", c, busy, c <= 9); end
            compared++; if (done !== (c == 10)) begin mismatched++; $display("[TB] FAIL free_done c=%0d: got %b expected %b", c, done, c == 10); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int reads;
        reads = 0;
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c <= 7; c++) begin
            out_ready = (c < 2);
            #1;
            if (rd_en) reads++;
            if (c >= 2) begin
                compared++; if (out_valid !== 1'b1 || out_data !== 8'h10 || out_addr !== 3'd0) begin
                    mismatched++; $display("[TB] FAIL bp_hold c=%0d: got v=%b %h/%0d expected v=1 10/0", c, out_valid, out_data, out_addr);
                end
            end
            step();
        end
        compared++; if (reads != 2) begin mismatched++; $display("[TB] FAIL bp_reads: got %0d expected 2", reads); end
        out_ready = 1'b1;
        for (int c = 8; c <= 16; c++) begin
            #1;
            if (c <= 15) begin
                compared++; if (out_valid !== 1'b1 || out_addr !== 3'(c - 8) || out_data !== 8'(8'h10 + c - 8)) begin
                    mismatched++; $display("[TB] FAIL bp_release c=%0d: got v=%b %0d/%h expected v=1 %0d/%h", c, out_valid, out_addr, out_data, c - 8, 8'h10 + c - 8);
                end
            end else begin
                compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_done: got %b expected 1", done); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int words, dones;
        words = 0; dones = 0;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c <= 20; c++) begin
            start = (c == 3) || (c == 10);
            #1;
            if (out_valid && out_ready) begin
                compared++; if (words > 7 || out_addr !== 3'(words) || out_data !== mem[words % 8]) begin
                    mismatched++; $display("[TB] FAIL restart_word %0d: got %0d/%h expected %0d/%h", words, out_addr, out_data, words, mem[words % 8]);
                end
                words++;
            end
            if (done) dones++;
            if (c == 11 || c == 12) begin
                compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL restart_busy c=%0d: got %b expected 0", c, busy); end
            end
            step();
        end
        start = 1'b0;
        compared++; if (words != 8) begin mismatched++; $display("[TB] FAIL restart_words: got %0d expected 8", words); end
        compared++; if (dones != 1) begin mismatched++; $display("[TB] FAIL restart_dones: got %0d expected 1", dones); end
    endtask

    task automatic test_reset_mid();
        int words, dones;
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c <= 4; c++) begin
            reset = (c == 4);
            step();
        end
        reset = 1'b0;
        #1;
        compared++; if ({busy, rd_en, out_valid, done} !== 4'b0000 || rd_addr !== 3'd0 || out_data !== 8'd0 || out_addr !== 3'd0) begin
            mismatched++; $display("[TB] FAIL midreset_outputs: got b=%b r=%b v=%b d=%b a=%0d %h/%0d expected all 0", busy, rd_en, out_valid, done, rd_addr, out_data, out_addr);
        end
        for (int c = 0; c < 4; c++) begin
            compared++; if (out_valid !== 1'b0 || done !== 1'b0) begin
                mismatched++; $display("[TB] FAIL midreset_stale c=%0d: got v=%b d=%b expected 0/0", c, out_valid, done);
            end
            step();
        end
        words = 0; dones = 0;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        pulse_start();
        for (int c = 0; c < 16; c++) begin
            #1;
            if (out_valid && out_ready) begin
                compared++; if (words > 7 || out_addr !== 3'(words) || out_data !== mem[words % 8]) begin
                    mismatched++; $display("[TB] FAIL midreset_word %0d: got %0d/%h expected %0d/%h", words, out_addr, out_data, words, mem[words % 8]);
                end
                words++;
            end
            if (done) dones++;
            step();
        end
        compared++; if (words != 8 || dones != 1) begin
            mismatched++; $display("[TB] FAIL midreset_sweep: got %0d words %0d dones expected 8/1", words, dones);
        end
    endtask

    task automatic test_random();
        logic [10:0] exp_q [$];
        logic [10:0] exp_word;
        logic [7:0]  pd;
        logic [2:0]  pa;
        logic        stall, finished;
        int          issued, taken;
        for (int s = 0; s < 1000; s++) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) begin
                mem[i] = 8'($urandom);
                exp_q.push_back({3'(i), mem[i]});
            end
            out_ready = 1'b0;
            pulse_start();
            issued = 0; taken = 0; stall = 1'b0; finished = 1'b0; pd = '0; pa = '0;
            for (int c = 0; c < 200 && !finished; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (stall) begin
                    compared++; if (out_valid !== 1'b1 || out_data !== pd || out_addr !== pa) begin
                        mismatched++; $display("[TB] FAIL rand_stable s=%0d: got v=%b %0d/%h expected v=1 %0d/%h", s, out_valid, out_addr, out_data, pa, pd);
                    end
                end
                compared++; if (issued - taken > 2) begin
                    mismatched++; $display("[TB] FAIL rand_occupancy s=%0d: got %0d expected <= 2", s, issued - taken);
                end
                if (done && busy) begin
                    compared++; mismatched++; $display("[TB] FAIL rand_done_busy s=%0d: got 1/1 expected not both", s);
                end
                if (rd_en) issued++;
                if (out_valid && out_ready) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++; $display("[TB] FAIL rand_extra s=%0d: got %0d/%h expected no word", s, out_addr, out_data);
                    end else begin
                        exp_word = exp_q.pop_front();
                        if ({out_addr, out_data} !== exp_word) begin
                            mismatched++; $display("[TB] FAIL rand_word s=%0d: got %0d/%h expected %0d/%h", s, out_addr, out_data, exp_word[10:8], exp_word[7:0]);
                        end
                    end
                    taken++;
                end
                stall = out_valid && !out_ready;
                pd = out_data;
                pa = out_addr;
                if (done) begin
                    finished = 1'b1;
                    compared++; if (exp_q.size() != 0) begin
                        mismatched++; $display("[TB] FAIL rand_missing s=%0d: got %0d words left expected 0", s, exp_q.size());
                    end
                end
                step();
            end
            if (!finished) begin
                compared++; mismatched++;
                $display("[TB] FAIL rand_timeout s=%0d: got no done expected done within 200 cycles", s);
                reset = 1'b1; step(); reset = 1'b0; step();
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_single();
        mem1[0] = 8'($urandom);
        out_ready1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        compared++; if (rd_en1 !== 1'b1 || rd_addr1 !== 3'd0) begin mismatched++; $display("[TB] FAIL single_read: got %b/%0d expected 1/0", rd_en1, rd_addr1); end
        step();
        compared++; if (rd_en1 !== 1'b0 || out_valid1 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_c1: got rd_en=%b v=%b expected 0/0", rd_en1, out_valid1); end
        step();
        compared++; if (out_valid1 !== 1'b1 || out_addr1 !== 3'd0 || out_data1 !== mem1[0] || busy1 !== 1'b1) begin
            mismatched++; $display("[TB] FAIL single_word: got v=%b %0d/%h b=%b expected v=1 0/%h b=1", out_valid1, out_addr1, out_data1, busy1, mem1[0]);
        end
        step();
        compared++; if (done1 !== 1'b1 || busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL single_done: got d=%b b=%b v=%b expected 1/0/0", done1, busy1, out_valid1);
        end
        step();
        compared++; if (done1 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_done_pulse: got %b expected 0", done1); end
    endtask

    initial begin
        $display("[TB] reg_readback bench starting");
        test_reset();
        test_free_run();
        step();
        test_backpressure();
        step();
        test_back_to_back();
        test_reset_mid();
        step();
        test_random();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
